axi4_lite_top_design: RTL and testbench

- Self-contained AXI4-Lite loopback block: an AXI4-Lite master and an AXI4-Lite slave on one clock, joined by internal channel wiring.
- The master drives write-address, write-data and read-address transactions from the *_in operands.
- The slave captures the transferred values onto the *_out ports and returns OKAY responses, with read data taken from rdata_in.
- All channel handshake signals are exported for observation. Slave readiness is controlled externally through the *ready_in inputs.

---
 rtl/axi4_lite_pkg.sv | 20 ++
 rtl/axi4_lite_slave_port.sv | 131 +++++++++++++
 rtl/axi4_lite_top_design.sv | 184 ++++++++++++++++++
 tb/tb_axi4_lite_top_design.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared widths, response codes and FSM state type for the AXI4-Lite loopback block.
package axi4_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } fsm_state_e;

  // A channel transfer happens on an edge where both valid and ready are high.
  function automatic logic handshake(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_port.sv
// AXI4-Lite slave side: ready pass-through, capture registers and B/R response generation.
module axi4_lite_slave_port
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [2:0]          awprot_i,
  input  logic                awvalid_i,
  input  logic                awready_ctl_i,
  output logic                awready_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [2:0]          awprot_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  input  logic                wready_ctl_i,
  output logic                wready_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic                bready_i,
  output logic                bvalid_o,
  output logic [1:0]          bresp_o,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic [2:0]          arprot_i,
  input  logic                arvalid_i,
  input  logic                arready_ctl_i,
  output logic                arready_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [2:0]          arprot_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                rready_i,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o
);

  logic [ADDR_W-1:0]   awaddr_q, araddr_q;
  logic [2:0]          awprot_q, arprot_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_got_q, w_got_q, ar_got_q;
  logic                bvalid_q, rvalid_q;
  logic [1:0]          bresp_q, rresp_q;
  logic                aw_hs, w_hs, ar_hs;

  // Readiness is steered from outside; the bus sees it unchanged.
  assign awready_o = awready_ctl_i;
  assign wready_o  = wready_ctl_i;
  assign arready_o = arready_ctl_i;

  assign aw_hs = handshake(awvalid_i, awready_ctl_i);
  assign w_hs  = handshake(wvalid_i, wready_ctl_i);
  assign ar_hs = handshake(arvalid_i, arready_ctl_i);

  // Write path: capture AW and W independently, answer with B one edge after both are in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      awaddr_q <= '0;
      awprot_q <= 3'b000;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      if (aw_got_q && w_got_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= RESP_OKAY;
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
      end else if (bvalid_q && bready_i) begin
        bvalid_q <= 1'b0;
      end
      // Handshake flags are written after the clear so a fresh transfer is never lost.
      if (aw_hs) begin
        awaddr_q <= awaddr_i;
        awprot_q <= awprot_i;
        aw_got_q <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
        w_got_q <= 1'b1;
      end
    end
  end

  // Read path: capture AR, then present rdata_i with an OKAY response on the next edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      araddr_q <= '0;
      arprot_q <= 3'b000;
      ar_got_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else begin
      if (ar_got_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_i;
        rresp_q  <= RESP_OKAY;
        ar_got_q <= 1'b0;
      end else if (rvalid_q && rready_i) begin
        rvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        araddr_q <= araddr_i;
        arprot_q <= arprot_i;
        ar_got_q <= 1'b1;
      end
    end
  end

  assign awaddr_o = awaddr_q;
  assign awprot_o = awprot_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = wstrb_q;
  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign araddr_o = araddr_q;
  assign arprot_o = arprot_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign rresp_o  = rresp_q;

endmodule

// File: rtl/axi4_lite_top_design.sv
// AXI4-Lite loopback: master write/read FSMs driving an internal slave port.
// Note: aresetn is active-high and synchronous despite its name.
module axi4_lite_top_design
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   awaddr_in,
  output logic [ADDR_W-1:0]   awaddr_out,
  input  logic [2:0]          awprot_in,
  output logic [2:0]          awprot_out,
  output logic                awvalid,
  input  logic                awready_in,
  output logic                awready_out,
  input  logic [DATA_W-1:0]   wdata_in,
  output logic [DATA_W-1:0]   wdata_out,
  input  logic [DATA_W/8-1:0] wstrb_in,
  output logic [DATA_W/8-1:0] wstrb_out,
  output logic                wvalid,
  input  logic                wready_in,
  output logic                wready_out,
  output logic [1:0]          bresp,
  output logic                bvalid,
  output logic                bready,
  input  logic [ADDR_W-1:0]   araddr_in,
  output logic [ADDR_W-1:0]   araddr_out,
  input  logic [2:0]          arprot_in,
  output logic [2:0]          arprot_out,
  output logic                arvalid,
  input  logic                arready_in,
  output logic                arready_out,
  input  logic [DATA_W-1:0]   rdata_in,
  output logic [DATA_W-1:0]   rdata_out,
  output logic [1:0]          rresp,
  output logic                rvalid,
  output logic                rready
);

  fsm_state_e          wr_state_q, rd_state_q;
  logic [ADDR_W-1:0]   awaddr_q, araddr_q;
  logic [2:0]          awprot_q, arprot_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = handshake(awvalid_q, awready_out);
  assign w_hs  = handshake(wvalid_q, wready_out);
  assign b_hs  = handshake(bvalid, bready_q);
  assign ar_hs = handshake(arvalid_q, arready_out);
  assign r_hs  = handshake(rvalid, rready_q);

  // Master write FSM: latch operands, drive AW and W until each completes, then take B.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      wr_state_q <= IDLE;
      awaddr_q   <= '0;
      awprot_q   <= 3'b000;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        IDLE: begin
          awaddr_q   <= awaddr_in;
          awprot_q   <= awprot_in;
          wdata_q    <= wdata_in;
          wstrb_q    <= wstrb_in;
          awvalid_q  <= 1'b1;
          wvalid_q   <= 1'b1;
          wr_state_q <= REQ;
        end
        REQ: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          // Each channel is done once its valid is low or it is handshaking now.
          if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
            bready_q   <= 1'b1;
            wr_state_q <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            bready_q   <= 1'b0;
            wr_state_q <= IDLE;
          end
        end
        default: begin
          awvalid_q  <= 1'b0;
          wvalid_q   <= 1'b0;
          bready_q   <= 1'b0;
          wr_state_q <= IDLE;
        end
      endcase
    end
  end

  // Master read FSM: latch address, drive AR until accepted, then take R.
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      rd_state_q <= IDLE;
      araddr_q   <= '0;
      arprot_q   <= 3'b000;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      case (rd_state_q)
        IDLE: begin
          araddr_q   <= araddr_in;
          arprot_q   <= arprot_in;
          arvalid_q  <= 1'b1;
          rd_state_q <= REQ;
        end
        REQ: begin
          if (ar_hs) begin
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b1;
            rd_state_q <= RESP;
          end
        end
        RESP: begin
          if (r_hs) begin
            rready_q   <= 1'b0;
            rd_state_q <= IDLE;
          end
        end
        default: begin
          arvalid_q  <= 1'b0;
          rready_q   <= 1'b0;
          rd_state_q <= IDLE;
        end
      endcase
    end
  end

  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  axi4_lite_slave_port #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_slave (
    .clk_i        (aclk),
    .rst_i        (aresetn),
    .awaddr_i     (awaddr_q),
    .awprot_i     (awprot_q),
    .awvalid_i    (awvalid_q),
    .awready_ctl_i(awready_in),
    .awready_o    (awready_out),
    .awaddr_o     (awaddr_out),
    .awprot_o     (awprot_out),
    .wdata_i      (wdata_q),
    .wstrb_i      (wstrb_q),
    .wvalid_i     (wvalid_q),
    .wready_ctl_i (wready_in),
    .wready_o     (wready_out),
    .wdata_o      (wdata_out),
    .wstrb_o      (wstrb_out),
    .bready_i     (bready_q),
    .bvalid_o     (bvalid),
    .bresp_o      (bresp),
    .araddr_i     (araddr_q),
    .arprot_i     (arprot_q),
    .arvalid_i    (arvalid_q),
    .arready_ctl_i(arready_in),
    .arready_o    (arready_out),
    .araddr_o     (araddr_out),
    .arprot_o     (arprot_out),
    .rdata_i      (rdata_in),
    .rready_i     (rready_q),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata_out),
    .rresp_o      (rresp)
  );

endmodule

// File: tb/tb_axi4_lite_top_design.sv
// Randomized bench for the AXI4-Lite loopback, checked against a transaction-phase model.
module tb_axi4_lite_top_design;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr_in, awaddr_out, wdata_in, wdata_out, araddr_in, araddr_out, rdata_in, rdata_out;
  logic [2:0]  awprot_in, awprot_out, arprot_in, arprot_out;
  logic [3:0]  wstrb_in, wstrb_out;
  logic        awvalid, awready_in, awready_out, wvalid, wready_in, wready_out;
  logic        bvalid, bready, arvalid, arready_in, arready_out, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;

  axi4_lite_top_design dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr_in(awaddr_in), .awaddr_out(awaddr_out), .awprot_in(awprot_in), .awprot_out(awprot_out),
    .awvalid(awvalid), .awready_in(awready_in), .awready_out(awready_out),
    .wdata_in(wdata_in), .wdata_out(wdata_out), .wstrb_in(wstrb_in), .wstrb_out(wstrb_out),
    .wvalid(wvalid), .wready_in(wready_in), .wready_out(wready_out),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr_in(araddr_in), .araddr_out(araddr_out), .arprot_in(arprot_in), .arprot_out(arprot_out),
    .arvalid(arvalid), .arready_in(arready_in), .arready_out(arready_out),
    .rdata_in(rdata_in), .rdata_out(rdata_out), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  // Reference model: phase of each master transaction plus what the slave has been handed.
  int          wr_phase, rd_phase;          // 0 = start, 1 = requesting, 2 = awaiting response
  logic        m_awvalid, m_wvalid, m_bready, m_bvalid, m_arvalid, m_rready, m_rvalid;
  logic        aw_seen, w_seen, ar_seen;
  logic [31:0] cur_awaddr, cur_wdata, cur_araddr;
  logic [2:0]  cur_awprot, cur_arprot;
  logic [3:0]  cur_wstrb;
  logic [31:0] m_awaddr_out, m_wdata_out, m_araddr_out, m_rdata_out;
  logic [2:0]  m_awprot_out, m_arprot_out;
  logic [3:0]  m_wstrb_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    wr_phase = 0; rd_phase = 0;
    m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_bvalid = 0;
    m_arvalid = 0; m_rready = 0; m_rvalid = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    cur_awaddr = 0; cur_wdata = 0; cur_araddr = 0; cur_awprot = 0; cur_arprot = 0; cur_wstrb = 0;
    m_awaddr_out = 0; m_wdata_out = 0; m_araddr_out = 0; m_rdata_out = 0;
    m_awprot_out = 0; m_arprot_out = 0; m_wstrb_out = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit aw_xfer, w_xfer, b_xfer, ar_xfer, r_xfer;
    if (aresetn) begin
      model_reset();
      return;
    end
    aw_xfer = m_awvalid && awready_in;
    w_xfer  = m_wvalid && wready_in;
    b_xfer  = m_bvalid && m_bready;
    ar_xfer = m_arvalid && arready_in;
    r_xfer  = m_rvalid && m_rready;
    // slave write side: response one edge after both halves arrived
    if (aw_seen && w_seen) begin m_bvalid = 1; aw_seen = 0; w_seen = 0; end
    else if (b_xfer) m_bvalid = 0;
    if (aw_xfer) begin m_awaddr_out = cur_awaddr; m_awprot_out = cur_awprot; aw_seen = 1; end
    if (w_xfer)  begin m_wdata_out = cur_wdata; m_wstrb_out = cur_wstrb; w_seen = 1; end
    // slave read side
    if (ar_seen) begin m_rvalid = 1; m_rdata_out = rdata_in; ar_seen = 0; end
    else if (r_xfer) m_rvalid = 0;
    if (ar_xfer) begin m_araddr_out = cur_araddr; m_arprot_out = cur_arprot; ar_seen = 1; end
    // master write transaction
    if (wr_phase == 0) begin
      cur_awaddr = awaddr_in; cur_awprot = awprot_in; cur_wdata = wdata_in; cur_wstrb = wstrb_in;
      m_awvalid = 1; m_wvalid = 1; wr_phase = 1;
    end else if (wr_phase == 1) begin
      if (aw_xfer) m_awvalid = 0;
      if (w_xfer)  m_wvalid = 0;
      if (!m_awvalid && !m_wvalid) begin wr_phase = 2; m_bready = 1; end
    end else if (b_xfer) begin
      wr_phase = 0; m_bready = 0;
    end
    // master read transaction
    if (rd_phase == 0) begin
      cur_araddr = araddr_in; cur_arprot = arprot_in; m_arvalid = 1; rd_phase = 1;
    end else if (rd_phase == 1) begin
      if (ar_xfer) begin m_arvalid = 0; m_rready = 1; rd_phase = 2; end
    end else if (r_xfer) begin
      rd_phase = 0; m_rready = 0;
    end
  endtask

  task automatic check_all();
    chk("awvalid", awvalid, m_awvalid);
    chk("wvalid", wvalid, m_wvalid);
    chk("bready", bready, m_bready);
    chk("bvalid", bvalid, m_bvalid);
    chk("bresp", bresp, 2'b00);
    chk("arvalid", arvalid, m_arvalid);
    chk("rready", rready, m_rready);
    chk("rvalid", rvalid, m_rvalid);
    chk("rresp", rresp, 2'b00);
    chk("awaddr_out", awaddr_out, m_awaddr_out);
    chk("awprot_out", awprot_out, m_awprot_out);
    chk("wdata_out", wdata_out, m_wdata_out);
    chk("wstrb_out", wstrb_out, m_wstrb_out);
    chk("araddr_out", araddr_out, m_araddr_out);
    chk("arprot_out", arprot_out, m_arprot_out);
    chk("rdata_out", rdata_out, m_rdata_out);
    chk("awready_out", awready_out, awready_in);
    chk("wready_out", wready_out, wready_in);
    chk("arready_out", arready_out, arready_in);
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
    check_all();
  endtask

  task automatic set_ready(input logic aw, input logic w, input logic ar);
    awready_in = aw; wready_in = w; arready_in = ar;
  endtask

  task automatic rand_operands();
    awaddr_in = $urandom; awprot_in = 3'($urandom); wdata_in = $urandom; wstrb_in = 4'($urandom);
    araddr_in = $urandom; arprot_in = 3'($urandom); rdata_in = $urandom;
  endtask

  initial begin
    model_reset();
    aresetn = 1'b1;
    set_ready(1'b0, 1'b0, 1'b0);
    awaddr_in = 32'd16; awprot_in = 3'd3; wdata_in = 32'hF0B4A596; wstrb_in = 4'b1011;
    araddr_in = 32'd32; arprot_in = 3'd5; rdata_in = 32'hF0B4A596;

    // reset for 5 cycles: everything zero
    repeat (5) tick();
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_awaddr_out", awaddr_out, 32'd0);

    // release with ready low: requests stall with valids high
    aresetn = 1'b0;
    repeat (4) tick();
    chk("stall_awvalid", awvalid, 1'b1);
    chk("stall_wvalid", wvalid, 1'b1);
    chk("stall_arvalid", arvalid, 1'b1);
    chk("stall_rvalid", rvalid, 1'b0);

    // AW alone
    set_ready(1'b1, 1'b0, 1'b0);
    tick();
    chk("aw_addr", awaddr_out, 32'd16);
    chk("aw_prot", awprot_out, 3'd3);
    chk("aw_valid_drop", awvalid, 1'b0);
    chk("aw_wvalid_held", wvalid, 1'b1);
    chk("aw_no_b", bvalid, 1'b0);

    // W completes the write, B pulses once
    set_ready(1'b0, 1'b1, 1'b0);
    tick();
    chk("w_data", wdata_out, 32'hF0B4A596);
    chk("w_strb", wstrb_out, 4'b1011);
    set_ready(1'b0, 1'b0, 1'b0);
    tick();
    chk("b_valid", bvalid, 1'b1);
    chk("b_ready", bready, 1'b1);
    tick();
    chk("b_pulse_end", bvalid, 1'b0);
    tick();
    chk("new_write", awvalid, 1'b1);

    // read
    set_ready(1'b0, 1'b0, 1'b1);
    tick();
    chk("ar_addr", araddr_out, 32'd32);
    chk("ar_prot", arprot_out, 3'd5);
    set_ready(1'b0, 1'b0, 1'b0);
    rdata_in = 32'hF0B4A596;
    tick();
    chk("r_valid", rvalid, 1'b1);
    chk("r_data", rdata_out, 32'hF0B4A596);
    chk("r_ready", rready, 1'b1);
    tick();
    chk("r_pulse_end", rvalid, 1'b0);
    chk("r_data_hold", rdata_out, 32'hF0B4A596);

    // back-to-back with all ready, then a 3-cycle stall, then resume
    set_ready(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin rand_operands(); tick(); end
    set_ready(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    set_ready(1'b1, 1'b1, 1'b1);
    repeat (12) tick();

    // random readiness, operands and occasional reset
    for (int i = 0; i < 3000; i++) begin
      rand_operands();
      set_ready($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      aresetn = ($urandom_range(0, 299) == 0);
      tick();
    end

    // reset while a write request is outstanding
    aresetn = 1'b0;
    set_ready(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !m_awvalid; i++) tick();
    chk("pre_rst_awvalid", awvalid, 1'b1);
    aresetn = 1'b1;
    tick();
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_wdata_out", wdata_out, 32'd0);
    aresetn = 1'b0;
    tick();
    chk("restart_awvalid", awvalid, 1'b1);
    chk("restart_bvalid", bvalid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
